seq_mag_comparator: RTL

SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

---
 rtl/seq_cmp_pkg.sv | 16 +
 rtl/seq_mag_comparator_digit.sv | 18 +
 rtl/seq_mag_comparator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seq_cmp_pkg.sv
// Shared encodings for the digit-serial magnitude comparator: FSM states and
// one-hot result codes ordered {gt, eq, lt}.
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] GT   = 3'b100;
    localparam logic [2:0] EQ   = 3'b010;
    localparam logic [2:0] LT   = 3'b001;
    localparam logic [2:0] NONE = 3'b000;

endpackage

// File: rtl/seq_mag_comparator_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    always_comb begin
        gt = (x > y);
        eq = (x == y);
        lt = (x < y);
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Digit-serial magnitude comparator, MSB digit first, unsigned or two's complement.
// Define SEQ_CMP_EARLY_EXIT_EN to leave SCAN at the first unequal digit.
module seq_mag_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
);

    localparam int N_DIG = WIDTH / DIGIT;
    localparam int CW    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_DIG - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    j_q, j_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [2:0]       res_q, res_d;
`ifndef SEQ_CMP_EARLY_EXIT_EN
    logic [2:0]       pend_q, pend_d;
`endif

    logic [DIGIT-1:0] a_dig [N_DIG];
    logic [DIGIT-1:0] b_dig [N_DIG];
    logic [DIGIT-1:0] x, y;
    logic             d_gt, d_eq, d_lt;
    logic [2:0]       cur;

    for (genvar g = 0; g < N_DIG; g++) begin : g_dig
        assign a_dig[g] = a_q[WIDTH-1-g*DIGIT -: DIGIT];
        assign b_dig[g] = b_q[WIDTH-1-g*DIGIT -: DIGIT];
    end

    // Flipping the sign bit maps two's complement onto unsigned order.
    always_comb begin
        x = a_dig[j_q];
        y = b_dig[j_q];
        if (sgn_q && (j_q == '0)) begin
            x[DIGIT-1] = ~x[DIGIT-1];
            y[DIGIT-1] = ~y[DIGIT-1];
        end
    end

    digit_compare #(.DIGIT(DIGIT)) u_digit (
        .x  (x),
        .y  (y),
        .gt (d_gt),
        .eq (d_eq),
        .lt (d_lt)
    );

    always_comb begin
        cur = d_gt ? GT : (d_lt ? LT : EQ);
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        res_d   = res_q;
`ifndef SEQ_CMP_EARLY_EXIT_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = signed_mode;
                    j_d     = '0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
                    pend_d  = NONE;
`endif
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
                if (!d_eq || (j_q == LAST)) begin
                    res_d   = cur;
                    j_d     = '0;
                    state_d = DONE;
                end else begin
                    j_d = j_q + 1'b1;
                end
`else
                // The first unequal digit is latched; later digits cannot override it.
                if ((pend_q == NONE) && !d_eq) begin
                    pend_d = cur;
                end
                if (j_q == LAST) begin
                    res_d   = (pend_q != NONE) ? pend_q : cur;
                    j_d     = '0;
                    state_d = DONE;
                end else begin
                    j_d = j_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            res_q   <= NONE;
`ifndef SEQ_CMP_EARLY_EXIT_EN
            pend_q  <= NONE;
`endif
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            res_q   <= res_d;
`ifndef SEQ_CMP_EARLY_EXIT_EN
            pend_q  <= pend_d;
`endif
        end
    end

    always_comb begin
        busy   = (state_q == SCAN);
        done   = (state_q == DONE);
        a_gt_b = res_q[2];
        a_eq_b = res_q[1];
        a_lt_b = res_q[0];
    end

endmodule
